// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single-write-port register file.
// Two sources (ALU = 0, memory load = 1) each feed a small FIFO. The head
// entries compete round-robin for one registered write per cycle.
// A pending-write bitmap covers queued and in-flight writes so the control
// FSM can stall reads of registers that still have a write outstanding.

// Per-source writeback FIFO with a per-register pending bitmap.
module rf_wb_fifo #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int DEPTH     = 2,
    parameter int ZERO_DROP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [AW-1:0]         push_addr,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic                  empty,
    output logic [AW-1:0]         head_addr,
    output logic [DW-1:0]         head_data,
    output logic [(1<<AW)-1:0]    pend
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             drop;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the stored count only, so a pop in the same cycle
    // never makes a full FIFO ready.
    assign push_ready = !rst && (count != CW'(DEPTH));
    assign empty      = (count == '0);

    // A register-0 write completes its handshake but is never stored.
    assign drop    = (ZERO_DROP != 0) && (push_addr == '0);
    assign do_push = push_valid && push_ready && !drop;
    assign do_pop  = pop && !empty;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Entry storage: written on push, read through the head pointer.
    // NOTE: storage is not reset; the vld bits and count decide which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, count and valid-bit bookkeeping; reset empties the FIFO.
    // NOTE: non-blocking assignments so every update sees pre-edge values,
    // which makes simultaneous push and pop behave as two independent edits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending bitmap: one bit per destination of every stored entry.
    // NOTE: pend gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) begin
                pend[addr_mem[i]] = 1'b1;
            end
        end
    end

endmodule

// Top level: two source FIFOs, round-robin grant, registered write port.
module rf_wb_arbiter #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int DEPTH     = 2,
    parameter int ZERO_DROP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [AW-1:0]         alu_addr,
    input  logic [DW-1:0]         alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [AW-1:0]         mem_addr,
    input  logic [DW-1:0]         mem_data,
    output logic [AW-1:0]         rwr,
    output logic [DW-1:0]         dwr,
    output logic                  wen,
    output logic [(1<<AW)-1:0]    pend,
    output logic                  idle
);

    localparam int NREG = 1 << AW;

    logic            alu_empty;
    logic            mem_empty;
    logic [AW-1:0]   alu_head_addr;
    logic [AW-1:0]   mem_head_addr;
    logic [DW-1:0]   alu_head_data;
    logic [DW-1:0]   mem_head_data;
    logic [NREG-1:0] alu_pend;
    logic [NREG-1:0] mem_pend;
    logic [NREG-1:0] wen_pend;

    logic            rr_ptr;       // source preferred on the next contested grant
    logic            grant_valid;
    logic            grant_src;
    logic            contested;
    logic            alu_pop;
    logic            mem_pop;

    rf_wb_fifo #(
        .DW        (DW),
        .AW        (AW),
        .DEPTH     (DEPTH),
        .ZERO_DROP (ZERO_DROP)
    ) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (alu_valid),
        .push_ready (alu_ready),
        .push_addr  (alu_addr),
        .push_data  (alu_data),
        .pop        (alu_pop),
        .empty      (alu_empty),
        .head_addr  (alu_head_addr),
        .head_data  (alu_head_data),
        .pend       (alu_pend)
    );

    rf_wb_fifo #(
        .DW        (DW),
        .AW        (AW),
        .DEPTH     (DEPTH),
        .ZERO_DROP (ZERO_DROP)
    ) u_mem_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (mem_valid),
        .push_ready (mem_ready),
        .push_addr  (mem_addr),
        .push_data  (mem_data),
        .pop        (mem_pop),
        .empty      (mem_empty),
        .head_addr  (mem_head_addr),
        .head_data  (mem_head_data),
        .pend       (mem_pend)
    );

    assign contested = !alu_empty && !mem_empty;

    // Grant selection from pre-edge FIFO state: sole requester wins,
    // otherwise the round-robin pointer decides.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = 1'b0;
        if (contested) begin
            grant_valid = 1'b1;
            grant_src   = rr_ptr;
        end else if (!alu_empty) begin
            grant_valid = 1'b1;
            grant_src   = 1'b0;
        end else if (!mem_empty) begin
            grant_valid = 1'b1;
            grant_src   = 1'b1;
        end
    end

    assign alu_pop = !rst && grant_valid && (grant_src == 1'b0);
    assign mem_pop = !rst && grant_valid && (grant_src == 1'b1);

    // Registered write port and round-robin pointer; the pointer only
    // moves when both sources competed for the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen    <= 1'b0;
            rwr    <= '0;
            dwr    <= '0;
            rr_ptr <= 1'b0;
        end else begin
            wen <= grant_valid;
            if (grant_valid) begin
                rwr <= grant_src ? mem_head_addr : alu_head_addr;
                dwr <= grant_src ? mem_head_data : alu_head_data;
            end
            if (contested) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    // In-flight write contributes its destination to the pending bitmap.
    always_comb begin
        wen_pend = '0;
        if (wen) begin
            wen_pend[rwr] = 1'b1;
        end
    end

    assign pend = alu_pend | mem_pend | wen_pend;
    assign idle = alu_empty && mem_empty && !wen;

endmodule
